// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry
//   Calculator-style digit entry front end for the BCD-to-binary converter.
//   Keys arrive one per valid/ready handshake. Digits shift into a packed BCD
//   register from the right, backspace shifts them back out, clear empties the
//   register, and enter commits the value to out_bcd behind a valid/ready
//   handshake. Only decimal digits ever reach the register, so the committed
//   value is always legal BCD.
//
// Parameters
//   DECLEN    number of BCD digits held (>= 1)
//   CW        digit counter width, derived from DECLEN
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   key_valid  key code present
//   key_code   0-9 digit, A backspace, B clear, C enter, D-F ignored
//   key_ready  block accepts a key (ENTRY state)
//   entry_bcd  live entry register, digit 0 in [3:0]
//   count      significant digits entered, 0..DECLEN
//   full       count == DECLEN
//   err        one-cycle pulse when a digit is rejected because full
//   out_bcd    committed value
//   out_valid  out_bcd holds an unconsumed value
//   out_ready  downstream accepts out_bcd
module bcd_digit_entry #(
    parameter int DECLEN = 9,
    localparam int CW = $clog2(DECLEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic                  key_ready,
    output logic [DECLEN*4-1:0]   entry_bcd,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  err,
    output logic [DECLEN*4-1:0]   out_bcd,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int W = DECLEN * 4;

    localparam logic [3:0] KEY_BS    = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t         state;
    logic           accept;
    logic           is_digit;
    logic           lead_zero;
    logic [W-1:0]   shl;   // register with the new digit shifted in
    logic [W-1:0]   shr;   // register with the last digit shifted out

    // A single-digit register has no upper digits to keep, so the shifts
    // collapse to "load the digit" and "empty".
    generate
        if (DECLEN == 1) begin : g_one
            assign shl = key_code;
            assign shr = '0;
        end else begin : g_multi
            assign shl = {entry_bcd[W-5:0], key_code};
            assign shr = {4'h0, entry_bcd[W-1:4]};
        end
    endgenerate

    assign key_ready = (state == ENTRY);
    assign accept    = key_valid && key_ready;
    assign full      = (count == CW'(DECLEN));
    assign is_digit  = (key_code <= 4'd9);
    // A zero typed into an empty register is not significant; dropping it
    // keeps count equal to the number of significant digits.
    assign lead_zero = (count == '0) && (key_code == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ENTRY;
            entry_bcd <= '0;
            count     <= '0;
            err       <= 1'b0;
            out_bcd   <= '0;
            out_valid <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ENTRY: begin
                    if (accept) begin
                        if (is_digit) begin
                            if (full) begin
                                err <= 1'b1;
                            end else if (!lead_zero) begin
                                entry_bcd <= shl;
                                count     <= count + CW'(1);
                            end
                        end else begin
                            case (key_code)
                                KEY_BS: begin
                                    if (count != '0) begin
                                        entry_bcd <= shr;
                                        count     <= count - CW'(1);
                                    end
                                end
                                KEY_CLEAR: begin
                                    entry_bcd <= '0;
                                    count     <= '0;
                                end
                                KEY_ENTER: begin
                                    out_bcd   <= entry_bcd;
                                    out_valid <= 1'b1;
                                    entry_bcd <= '0;
                                    count     <= '0;
                                    state     <= HOLD;
                                end
                                default: ;  // D-F: accepted and dropped
                            endcase
                        end
                    end
                end
                HOLD: begin
                    // out_bcd is left in place after consume; only the flag drops.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ENTRY;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_entry.sv
module tb_bcd_digit_entry;

    localparam int DECLEN = 9;
    localparam int CW     = $clog2(DECLEN + 1);
    localparam int W      = DECLEN * 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_valid = 1'b0;
    logic [3:0]    key_code = 4'h0;
    logic          key_ready;
    logic [W-1:0]  entry_bcd;
    logic [CW-1:0] count;
    logic          full;
    logic          err;
    logic [W-1:0]  out_bcd;
    logic          out_valid;
    logic          out_ready = 1'b0;

    bcd_digit_entry #(.DECLEN(DECLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .entry_bcd (entry_bcd),
        .count     (count),
        .full      (full),
        .err       (err),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [W-1:0] entry;
        int           cnt;
        logic         full;
        logic         err;
        logic         ov;
        logic         kr;
        logic [W-1:0] outb;
    } exp_t;

    exp_t         eq[$];   // expected visible state, tagged with the cycle it applies to
    logic [W-1:0] cq[$];   // expected committed values, checked at each consume
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compares the visible state against whatever the stimulus
    // predicted for this cycle, and checks out_bcd at each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            while (eq.size() > 0 && eq[0].cyc <= cyc) begin
                exp_t e;
                e = eq.pop_front();
                chk("entry_bcd", 64'(entry_bcd), 64'(e.entry));
                chk("count",     64'(count),     64'(e.cnt));
                chk("full",      64'(full),      64'(e.full));
                chk("err",       64'(err),       64'(e.err));
                chk("out_valid", 64'(out_valid), 64'(e.ov));
                chk("key_ready", 64'(key_ready), 64'(e.kr));
                chk("out_bcd",   64'(out_bcd),   64'(e.outb));
            end
            if (out_valid && out_ready) begin
                if (cq.size() == 0) chk("commit_q_empty", 64'(1), 64'(0));
                else chk("commit", 64'(out_bcd), 64'(cq.pop_front()));
            end
        end
    end

    // Drive one cycle of inputs and predict the state after the next edge.
    task automatic step(input logic kv, input logic [3:0] kc, input logic ordy,
                        input logic [W-1:0] e_ent, input int e_cnt,
                        input logic e_full, input logic e_err,
                        input logic e_ov, input logic e_kr,
                        input logic [W-1:0] e_out);
        exp_t e;
        @(posedge clk);
        #1;
        key_valid = kv;
        key_code  = kc;
        out_ready = ordy;
        e.cyc = cyc + 1;
        e.entry = e_ent; e.cnt = e_cnt; e.full = e_full; e.err = e_err;
        e.ov = e_ov; e.kr = e_kr; e.outb = e_out;
        eq.push_back(e);
    endtask

    initial begin
        logic [W-1:0] nines;
        int t;

        // Reset with a key presented: nothing may be accepted.
        key_valid = 1'b1;
        key_code  = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_entry",  64'(entry_bcd), 64'(0));
        chk("rst_count",  64'(count),     64'(0));
        chk("rst_full",   64'(full),      64'(0));
        chk("rst_err",    64'(err),       64'(0));
        chk("rst_ov",     64'(out_valid), 64'(0));
        chk("rst_kr",     64'(key_ready), 64'(1));
        chk("rst_out",    64'(out_bcd),   64'(0));
        rst = 1'b0;
        key_valid = 1'b0;

        step(0, 4'h0, 0, 'h0, 0, 0, 0, 0, 1, 'h0);

        // Basic entry, back to back.
        step(1, 4'h1, 0, 'h1,   1, 0, 0, 0, 1, 'h0);
        step(1, 4'h2, 0, 'h12,  2, 0, 0, 0, 1, 'h0);
        step(1, 4'h3, 0, 'h123, 3, 0, 0, 0, 1, 'h0);
        step(1, 4'hB, 0, 'h0,   0, 0, 0, 0, 1, 'h0);

        // Leading zeros and backspace, including backspace on empty.
        step(1, 4'h0, 0, 'h0, 0, 0, 0, 0, 1, 'h0);
        step(1, 4'h0, 0, 'h0, 0, 0, 0, 0, 1, 'h0);
        step(1, 4'h7, 0, 'h7, 1, 0, 0, 0, 1, 'h0);
        step(1, 4'hA, 0, 'h0, 0, 0, 0, 0, 1, 'h0);
        step(1, 4'hA, 0, 'h0, 0, 0, 0, 0, 1, 'h0);
        step(1, 4'hA, 0, 'h0, 0, 0, 0, 0, 1, 'h0);

        // Fill with nines, overflow, one-cycle err, clear.
        nines = '0;
        for (int i = 1; i <= DECLEN; i++) begin
            nines = (nines << 4) | W'(9);
            step(1, 4'h9, 0, nines, i, (i == DECLEN), 0, 0, 1, 'h0);
        end
        step(1, 4'h5, 0, 36'h999999999, 9, 1, 1, 0, 1, 'h0);
        step(0, 4'h0, 0, 36'h999999999, 9, 1, 0, 0, 1, 'h0);
        step(1, 4'hB, 0, 'h0, 0, 0, 0, 0, 1, 'h0);

        // Commit 42, stall five cycles with a key pending, then consume.
        step(1, 4'h4, 0, 'h4,  1, 0, 0, 0, 1, 'h0);
        step(1, 4'h2, 0, 'h42, 2, 0, 0, 0, 1, 'h0);
        step(1, 4'hC, 0, 'h0,  0, 0, 0, 1, 0, 'h42);
        cq.push_back('h42);
        repeat (5) step(1, 4'h7, 0, 'h0, 0, 0, 0, 1, 0, 'h42);
        step(0, 4'h0, 1, 'h0, 0, 0, 0, 0, 1, 'h42);

        // Ignored codes, then an empty enter commits zero.
        step(1, 4'hE, 0, 'h0, 0, 0, 0, 0, 1, 'h42);
        step(1, 4'hF, 0, 'h0, 0, 0, 0, 0, 1, 'h42);
        step(1, 4'hC, 0, 'h0, 0, 0, 0, 1, 0, 'h0);
        cq.push_back('h0);
        step(0, 4'h0, 1, 'h0, 0, 0, 0, 0, 1, 'h0);

        // Commit 3, then reset mid-cycle while it is held.
        step(1, 4'h3, 0, 'h3, 1, 0, 0, 0, 1, 'h0);
        step(1, 4'hC, 0, 'h0, 0, 0, 0, 1, 0, 'h3);
        cq.push_back('h3);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        key_valid = 1'b0;
        #1;
        chk("arst_ov",    64'(out_valid), 64'(0));
        chk("arst_out",   64'(out_bcd),   64'(0));
        chk("arst_count", 64'(count),     64'(0));
        chk("arst_kr",    64'(key_ready), 64'(1));
        chk("arst_entry", 64'(entry_bcd), 64'(0));
        cq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(1, 4'h8, 0, 'h8, 1, 0, 0, 0, 1, 'h0);
        step(0, 4'h0, 0, 'h8, 1, 0, 0, 0, 1, 'h0);

        // Let the monitor drain, bounded.
        t = 0;
        while ((eq.size() > 0 || cq.size() > 0) && t < 20) begin
            @(posedge clk);
            t++;
        end
        chk("drain", 64'(eq.size() + cq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
